// File: rtl/store_write_buffer_if.sv
// ----------------------------------------------------------------------------
// store_write_buffer_if
// Purpose : Bundles the store-side handshake, the load-forwarding lookup and the
//           data-memory write handshake of the MEM-stage store write buffer.
// Modports:
//   slave  - the store write buffer itself
//            in : st_valid, st_addr, st_data, ld_addr, mem_ack
//            out: st_ready, ld_hit, ld_data, mem_req, mem_addr, mem_wdata
//   master - the surrounding pipeline / memory (opposite directions)
// ----------------------------------------------------------------------------
interface store_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Store side (EXE/MEM latch -> buffer)
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;

    // Load forwarding lookup
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;

    // Data memory write port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_ack,
        output st_ready, ld_hit, ld_data, mem_req, mem_addr, mem_wdata
    );

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_ack,
        input  st_ready, ld_hit, ld_data, mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_write_buffer.sv
// ----------------------------------------------------------------------------
// store_write_buffer
// Purpose : Write side of the MEM stage. Queues sw stores in a circular FIFO and
//           drains them in acceptance order into data memory over a req/ack
//           handshake, back-to-back with no bubble while entries remain.
// Ports   :
//   clk    - rising-edge clock
//   rst    - synchronous reset, active-high
//   bus    - store_write_buffer_if.slave (store handshake, load lookup,
//            memory write handshake)
//   count  - occupied entries
//   empty  - count == 0
//   full   - count == DEPTH (st_ready = !full)
// Config  : define STB_LDFWD_EN to build store-to-load forwarding. Without it
//           ld_hit/ld_data are tied to 0 and the pipeline must stall loads
//           until empty.
// ----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH  = 4,   // power of two, 2..16
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    store_write_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t            state_q, state_n;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q;

    logic              mem_req_q,   mem_req_n;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;

    logic              push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign bus.st_ready  = !full;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // A full buffer refuses stores even if the head drains this same cycle.
    assign push = bus.st_valid && !full;
    // Only a request actually on the bus can be acknowledged; stray acks are ignored.
    assign pop  = (state_q == WRITE) && bus.mem_ack;

    // Power-of-two depth, so the natural pointer overflow is the modulo wrap.
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: the entry arrays carry no reset; an entry is only ever read while
    // count marks it valid, so clearing it would add muxes for no behaviour.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus.st_addr;
            data_mem[wr_ptr_q] <= bus.st_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, FSM state and registered memory outputs
    // ------------------------------------------------------------------
    // NOTE: every sequential assignment is non-blocking so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nxt;

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            state_q     <= state_n;
            mem_req_q   <= mem_req_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM next-state / next-output
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, which keeps the
    // block purely combinational (no inferred latches) on any path.
    always_comb begin
        state_n     = state_q;
        mem_req_n   = mem_req_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                // Registered count: a store accepted this edge is seen next cycle.
                if (count_q != '0) begin
                    state_n     = WRITE;
                    mem_req_n   = 1'b1;
                    mem_addr_n  = addr_mem[rd_ptr_q];
                    mem_wdata_n = data_mem[rd_ptr_q];
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    if (count_q > CNT_W'(1)) begin
                        // Next older entry already stored: issue it without a bubble.
                        mem_req_n   = 1'b1;
                        mem_addr_n  = addr_mem[rd_ptr_nxt];
                        mem_wdata_n = data_mem[rd_ptr_nxt];
                    end else if (push) begin
                        // Head was the last entry but a store lands this same edge;
                        // take it straight from the input since the array write
                        // is not visible until after the edge.
                        mem_req_n   = 1'b1;
                        mem_addr_n  = bus.st_addr;
                        mem_wdata_n = bus.st_data;
                    end else begin
                        state_n   = IDLE;
                        mem_req_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store-to-load forwarding
    // ------------------------------------------------------------------
`ifdef STB_LDFWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Walk oldest to youngest so a later match overrides: youngest wins.
    // The in-flight head stays valid until its ack edge, so it still forwards.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem[idx] == bus.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end

    assign bus.ld_hit  = fwd_hit;
    assign bus.ld_data = fwd_data;
`else
    assign bus.ld_hit  = 1'b0;
    assign bus.ld_data = '0;
`endif

endmodule
